// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: decode/writeback/bypass inputs and EX-facing slot outputs of the OF stage
interface operand_fetch_stage_if #(parameter int XLEN = 32, parameter int IMMW = 18);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_rs1;
  logic [3:0]      in_rs2;
  logic [3:0]      in_rd;
  logic [IMMW-1:0] in_imm;
  logic [1:0]      in_imm_mod;
  logic            in_use_imm;
  logic [3:0]      in_alu_op;
  logic            in_wb_en;
  logic            wb_en;
  logic [3:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            fwd_valid;
  logic [3:0]      fwd_addr;
  logic [XLEN-1:0] fwd_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [XLEN-1:0] out_st_data;
  logic [3:0]      out_op;
  logic [3:0]      out_rd;
  logic            out_wb_en;
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_imm, in_imm_mod, in_use_imm, in_alu_op, in_wb_en,
    input  wb_en, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_st_data, out_op, out_rd, out_wb_en
  );
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_imm, in_imm_mod, in_use_imm, in_alu_op, in_wb_en,
    output wb_en, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_st_data, out_op, out_rd, out_wb_en
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: 16x32 regfile, immediate expansion, bypass and one registered valid/ready slot.
// Define OF_FWD_BYPASS_EN to enable the EX-result bypass (fwd_*); otherwise only writeback bypass is used.
module operand_fetch_stage #(
  parameter int NREGS = 16,
  parameter int XLEN  = 32,
  parameter int IMMW  = 18
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_fetch_stage_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e          state_q, state_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, st_q, st_d;
  logic [3:0]      op_q, op_d, rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic            we_q, we_d, use_imm_q, use_imm_d;
  logic            accept, fire, fwd_v;
  logic [XLEN-1:0] imm_x, rs1_v, rs2_v;
`ifdef OF_FWD_BYPASS_EN
  assign fwd_v = bus.fwd_valid;
`else
  logic unused_fwd;
  assign fwd_v      = 1'b0;
  assign unused_fwd = ^{bus.fwd_valid, bus.fwd_addr, bus.fwd_data};
`endif
  // EX result beats writeback, writeback beats the value already held/read
  function automatic logic [XLEN-1:0] pick(input logic [3:0] a, input logic [XLEN-1:0] base);
    return (fwd_v && bus.fwd_addr == a) ? bus.fwd_data :
           (bus.wb_en && bus.wb_addr == a) ? bus.wb_data : base;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  always_comb
    state_d = bus.flush ? EMPTY : accept ? FULL : fire ? EMPTY : state_q;
  always_comb begin
    bus.out_valid = state_q == FULL;
    bus.in_ready  = !bus.flush && (state_q == EMPTY || bus.out_ready);
    accept        = bus.in_valid && bus.in_ready;
    fire          = bus.out_valid && bus.out_ready;
  end
  assign imm_x = bus.in_imm_mod == 2'b01 ? {{(XLEN-IMMW){1'b0}}, bus.in_imm} :
                 bus.in_imm_mod == 2'b10 ? {bus.in_imm[15:0], {(XLEN-16){1'b0}}} :
                                           {{(XLEN-IMMW){bus.in_imm[IMMW-1]}}, bus.in_imm};
  assign rs1_v = pick(bus.in_rs1, rf_q[bus.in_rs1]);
  assign rs2_v = pick(bus.in_rs2, rf_q[bus.in_rs2]);
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    st_d      = st_q;
    op_d      = op_q;
    rd_d      = rd_q;
    we_d      = we_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    use_imm_d = use_imm_q;
    if (accept) begin
      a_d       = rs1_v;
      b_d       = bus.in_use_imm ? imm_x : rs2_v;
      st_d      = rs2_v;
      op_d      = bus.in_alu_op;
      rd_d      = bus.in_rd;
      we_d      = bus.in_wb_en;
      rs1_d     = bus.in_rs1;
      rs2_d     = bus.in_rs2;
      use_imm_d = bus.in_use_imm;
    end else if (state_q == FULL && !fire) begin
      a_d  = pick(rs1_q, a_q);
      st_d = pick(rs2_q, st_q);
      b_d  = use_imm_q ? b_q : pick(rs2_q, b_q);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {a_q, b_q, st_q, op_q, rd_q, we_q} <= '0;
      {rs1_q, rs2_q, use_imm_q}          <= '0;
    end else begin
      {a_q, b_q, st_q, op_q, rd_q, we_q} <= {a_d, b_d, st_d, op_d, rd_d, we_d};
      {rs1_q, rs2_q, use_imm_q}          <= {rs1_d, rs2_d, use_imm_d};
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)          for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    else if (bus.wb_en)  rf_q[bus.wb_addr] <= bus.wb_data;
  assign bus.out_a       = a_q;
  assign bus.out_b       = b_q;
  assign bus.out_st_data = st_q;
  assign bus.out_op      = op_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_wb_en   = we_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed vectors, expected slot contents queued at issue, checked on each fire
module tb_operand_fetch_stage;
`ifdef OF_FWD_BYPASS_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] a, b, st;
    logic [3:0]  op, rd;
    logic        we;
  } exp_t;
  logic clk, rst_n;
  int   checks, errors;
  exp_t exp_q [$];
  operand_fetch_stage_if ifc ();
  operand_fetch_stage dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      exp_t got, e;
      got = {ifc.out_a, ifc.out_b, ifc.out_st_data, ifc.out_op, ifc.out_rd, ifc.out_wb_en};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fire_unexpected got a=%h b=%h st=%h", got.a, got.b, got.st);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL fire got a=%h b=%h st=%h op=%h rd=%h we=%b exp a=%h b=%h st=%h op=%h rd=%h we=%b",
                   got.a, got.b, got.st, got.op, got.rd, got.we, e.a, e.b, e.st, e.op, e.rd, e.we);
        end
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                      input logic [17:0] imm, input logic [1:0] mod, input logic ui,
                      input logic [3:0] op, input logic we,
                      input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] es,
                      input bit push);
    ifc.in_rs1 = rs1; ifc.in_rs2 = rs2; ifc.in_rd = rd; ifc.in_imm = imm; ifc.in_imm_mod = mod;
    ifc.in_use_imm = ui; ifc.in_alu_op = op; ifc.in_wb_en = we; ifc.in_valid = 1'b1;
    if (push) exp_q.push_back({ea, eb, es, op, rd, we});
    chk("in_ready_at_send", {31'b0, ifc.in_ready}, 32'd1);
    tick();
    ifc.in_valid = 1'b0;
  endtask
  task automatic wb(input logic en, input logic [3:0] a, input logic [31:0] d);
    ifc.wb_en = en; ifc.wb_addr = a; ifc.wb_data = d;
  endtask
  task automatic fwd(input logic en, input logic [3:0] a, input logic [31:0] d);
    ifc.fwd_valid = en; ifc.fwd_addr = a; ifc.fwd_data = d;
  endtask
  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    ifc.in_valid = 0; ifc.in_rs1 = 0; ifc.in_rs2 = 0; ifc.in_rd = 0; ifc.in_imm = 0;
    ifc.in_imm_mod = 0; ifc.in_use_imm = 0; ifc.in_alu_op = 0; ifc.in_wb_en = 0;
    wb(0, 0, 0); fwd(0, 0, 0); ifc.flush = 0; ifc.out_ready = 1;
    repeat (2) tick();
    chk("reset_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("reset_a", ifc.out_a, 0);
    chk("reset_b_st", ifc.out_b | ifc.out_st_data, 0);
    chk("reset_op_rd_we", {23'b0, ifc.out_op, ifc.out_rd, ifc.out_wb_en}, 0);
    rst_n = 1'b1;
    tick();
    // Test 1: write r3, then immediate forms on top of it
    wb(1, 3, 32'h0000_1234); tick(); wb(0, 0, 0);
    send(3, 0, 1, 18'h3FFFF, 2'b00, 1, 4'hA, 1, 32'h1234, 32'hFFFF_FFFF, 0, 1);
    chk("t1_valid", {31'b0, ifc.out_valid}, 32'd1);
    send(3, 0, 2, 18'h3FFFF, 2'b01, 1, 4'hB, 0, 32'h1234, 32'h0003_FFFF, 0, 1);
    send(3, 0, 3, 18'h2ABCD, 2'b10, 1, 4'hC, 1, 32'h1234, 32'hABCD_0000, 0, 1);
    send(3, 0, 4, 18'h20000, 2'b11, 1, 4'hD, 1, 32'h1234, 32'hFFFE_0000, 0, 1);
    // Test 2: bypass priority at accept
    wb(1, 5, 32'hAA); fwd(1, 5, 32'hBB);
    send(5, 5, 5, 0, 0, 0, 4'h1, 1, FWD ? 32'hBB : 32'hAA, FWD ? 32'hBB : 32'hAA, FWD ? 32'hBB : 32'hAA, 1);
    wb(0, 0, 0); fwd(1, 7, 32'h77);
    send(7, 0, 6, 0, 0, 0, 4'h2, 0, FWD ? 32'h77 : 32'h0, 0, 0, 1);
    fwd(0, 0, 0); wb(1, 6, 32'h66);
    send(6, 5, 7, 0, 0, 0, 4'h3, 1, 32'h66, 32'hAA, 32'hAA, 1);
    wb(0, 0, 0);
    tick();
    // Test 3: held-operand refresh while stalled
    ifc.out_ready = 0;
    send(3, 7, 8, 0, 0, 0, 4'h4, 1, 32'h1234, 32'h55, 32'h55, 1);
    wb(1, 7, 32'h55); tick(); wb(0, 0, 0);
    chk("t3_b_refresh", ifc.out_b, 32'h55);
    chk("t3_st_refresh", ifc.out_st_data, 32'h55);
    ifc.out_ready = 1; tick(); ifc.out_ready = 0;
    send(9, 7, 9, 18'd5, 2'b00, 1, 4'h5, 1, FWD ? 32'h99 : 32'h0, 32'h5, 32'h77, 1);
    fwd(1, 9, 32'h99); wb(1, 7, 32'h77); tick(); fwd(0, 0, 0); wb(0, 0, 0);
    chk("t3_b_imm_kept", ifc.out_b, 32'h5);
    ifc.out_ready = 1; tick();
    // Test 4: back-to-back, no bubbles
    for (int i = 0; i < 4; i++) begin
      send(3, 7, 4'(i), 18'(i * 16 + 1), 2'b01, 1, 4'(i), 1, 32'h1234, 32'(i * 16 + 1), 32'h77, 1);
      chk($sformatf("t4_valid_%0d", i), {31'b0, ifc.out_valid}, 32'd1);
    end
    tick();
    chk("t4_drained", {31'b0, ifc.out_valid}, 32'd0);
    // Test 5: flush kills the slot and blocks accept, writeback still lands
    ifc.out_ready = 0;
    send(3, 0, 1, 0, 0, 0, 4'h6, 1, 0, 0, 0, 0);
    ifc.in_valid = 1; ifc.in_rs1 = 1; ifc.flush = 1; wb(1, 10, 32'hA0A);
    #1;
    chk("t5_in_ready_flush", {31'b0, ifc.in_ready}, 32'd0);
    tick();
    ifc.flush = 0; ifc.in_valid = 0; wb(0, 0, 0);
    chk("t5_valid_after_flush", {31'b0, ifc.out_valid}, 32'd0);
    tick();
    chk("t5_not_taken", {31'b0, ifc.out_valid}, 32'd0);
    ifc.out_ready = 1;
    send(10, 0, 2, 0, 0, 0, 4'h7, 0, 32'hA0A, 0, 0, 1);
    tick();
    // Test 6: async reset mid-stall clears slot and regfile
    ifc.out_ready = 0;
    send(3, 10, 3, 0, 0, 0, 4'h8, 1, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("t6_valid_async", {31'b0, ifc.out_valid}, 32'd0);
    chk("t6_a_async", ifc.out_a, 0);
    tick(); tick();
    rst_n = 1; ifc.out_ready = 1;
    tick();
    for (int i = 0; i < 16; i++)
      send(4'(i), 4'(15 - i), 4'(i), 0, 0, 0, 4'h9, 1, 0, 0, 0, 1);
    tick(); tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
